// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and the multiplier scoreboard entry type
package cpu_pkg;

  localparam int MUL_STAGES = 5;
  localparam int REG_ID_W   = 5;
  localparam int DATA_W     = 32;
  localparam int INFL_W     = $clog2(MUL_STAGES + 1);

  // One scoreboard stage as seen by the hazard detection unit.
  typedef struct packed {
    logic                write_back;
    logic [REG_ID_W-1:0] rd_id;
  } mul_wb_t;

endpackage

// File: rtl/cpu_wb_skid.sv
// rtl/cpu_wb_skid.sv - one-entry skid buffer holding a commit write displaced by a MUL retirement
module cpu_wb_skid
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                capture_i,
  input  logic                drain_i,
  input  logic [REG_ID_W-1:0] cap_rd_i,
  input  logic [DATA_W-1:0]   cap_data_i,
  output logic                valid_o,
  output logic [REG_ID_W-1:0] rd_o,
  output logic [DATA_W-1:0]   data_o
);

  logic                valid_q, valid_d;
  logic [REG_ID_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]   data_q, data_d;

  // Capture is only requested while empty, so it never collides with a drain.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (capture_i) begin
      valid_d = 1'b1;
      rd_d    = cap_rd_i;
      data_d  = cap_data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign rd_o    = rd_q;
  assign data_o  = data_q;

endmodule

// File: rtl/cpu_mul_wb_scheduler.sv
// rtl/cpu_mul_wb_scheduler.sv - MUL in-flight scoreboard and register-file write port arbiter
module cpu_mul_wb_scheduler
  import cpu_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           stall,
  input  logic                           issue_valid,
  input  logic [REG_ID_W-1:0]            issue_rd,
  input  logic [DATA_W-1:0]              mul_data,
  input  logic                           commit_we,
  input  logic [REG_ID_W-1:0]            commit_rd,
  input  logic [DATA_W-1:0]              commit_data,
  output logic [MUL_STAGES-1:0]          mul_wb_valid,
  output logic [MUL_STAGES*REG_ID_W-1:0] mul_wb_rd,
  output logic                           skid_valid,
  output logic [REG_ID_W-1:0]            skid_rd,
  output logic                           wb_stall,
  output logic                           rf_we,
  output logic [REG_ID_W-1:0]            rf_waddr,
  output logic [DATA_W-1:0]              rf_wdata,
  output logic [INFL_W-1:0]              mul_inflight
);

  logic [MUL_STAGES-1:0] valid_q, valid_d;
  logic [REG_ID_W-1:0]   rd_q [MUL_STAGES];
  logic [REG_ID_W-1:0]   rd_d [MUL_STAGES];
  logic [DATA_W-1:0]     skid_data;
  logic                  mul_port, commit_ok, skid_capture, skid_drain;
  logic [INFL_W-1:0]     inflight;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    if (!stall) begin
      valid_d = {valid_q[MUL_STAGES-2:0], issue_valid};
      rd_d[0] = issue_rd;
      for (int i = 1; i < MUL_STAGES; i++) rd_d[i] = rd_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < MUL_STAGES; i++) rd_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_STAGES; i++) inflight = inflight + INFL_W'(valid_q[i]);
  end

  // reset_n gates the direct commit path so nothing reaches the RF while reset is held.
  assign mul_port     = !stall && valid_q[MUL_STAGES-1];
  assign commit_ok    = reset_n && commit_we && !stall && !skid_valid;
  assign skid_capture = commit_ok && mul_port;

  always_comb begin
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    skid_drain = 1'b0;
    if (mul_port) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q[MUL_STAGES-1];
      rf_wdata = mul_data;
    end else if (skid_valid) begin
      rf_we      = 1'b1;
      rf_waddr   = skid_rd;
      rf_wdata   = skid_data;
      skid_drain = 1'b1;
    end else if (commit_ok) begin
      rf_we    = 1'b1;
      rf_waddr = commit_rd;
      rf_wdata = commit_data;
    end
  end

  cpu_wb_skid u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture_i  (skid_capture),
    .drain_i    (skid_drain),
    .cap_rd_i   (commit_rd),
    .cap_data_i (commit_data),
    .valid_o    (skid_valid),
    .rd_o       (skid_rd),
    .data_o     (skid_data)
  );

  for (genvar g = 0; g < MUL_STAGES; g++) begin : g_rd_flat
    assign mul_wb_rd[g*REG_ID_W +: REG_ID_W] = rd_q[g];
  end

  assign mul_wb_valid = valid_q;
  assign wb_stall     = skid_valid;
  assign mul_inflight = inflight;

endmodule

// File: tb/tb_cpu_mul_wb_scheduler.sv
// tb/tb_cpu_mul_wb_scheduler.sv - directed self-checking bench for cpu_mul_wb_scheduler
module tb_cpu_mul_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset_n, stall, issue_valid, commit_we;
  logic [4:0]  issue_rd, commit_rd;
  logic [31:0] mul_data, commit_data;
  logic [4:0]  mul_wb_valid;
  logic [24:0] mul_wb_rd;
  logic        skid_valid, wb_stall, rf_we;
  logic [4:0]  skid_rd, rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  mul_inflight;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_mul_wb_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .mul_data     (mul_data),
    .commit_we    (commit_we),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .mul_wb_valid (mul_wb_valid),
    .mul_wb_rd    (mul_wb_rd),
    .skid_valid   (skid_valid),
    .skid_rd      (skid_rd),
    .wb_stall     (wb_stall),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .mul_inflight (mul_inflight)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, 32'(rf_we), 32'(we));
    if (we) begin
      chk({tag, ".waddr"}, 32'(rf_waddr), 32'(a));
      chk({tag, ".wdata"}, rf_wdata, d);
    end
  endtask

  initial begin
    reset_n = 1'b1; stall = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    mul_data = '0; commit_we = 1'b0; commit_rd = '0; commit_data = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst.valid", 32'(mul_wb_valid), 0);
    chk("rst.inflight", 32'(mul_inflight), 0);
    chk("rst.skid", 32'(skid_valid), 0);
    chk("rst.wb_stall", 32'(wb_stall), 0);
    chk_rf("rst.rf", 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // single MUL rd=7 walks the pipeline and writes at the result stage
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0; issue_rd = '0;
    chk("single.v0", 32'(mul_wb_valid), 32'h01);
    chk("single.rd0", 32'(mul_wb_rd[4:0]), 7);
    chk("single.infl", 32'(mul_inflight), 1);
    chk_rf("single.rf0", 1'b0, 0, 0);
    for (int i = 1; i < 5; i++) begin
      if (i == 4) mul_data = 32'hDEAD_BEEF;
      tick();
      chk("single.walk", 32'(mul_wb_valid), 32'(1 << i));
      chk("single.rdi", 32'(mul_wb_rd[i*5 +: 5]), 7);
    end
    chk_rf("single.rf4", 1'b1, 5'd7, 32'hDEAD_BEEF);
    tick();
    chk("single.done", 32'(mul_wb_valid), 0);
    chk_rf("single.idle", 1'b0, 0, 0);

    // conflict: MUL r3 retires while commit wants r9
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    repeat (4) tick();
    mul_data = 32'h33; commit_we = 1'b1; commit_rd = 5'd9; commit_data = 32'h99;
    #1;
    chk_rf("conf.mul", 1'b1, 5'd3, 32'h33);
    chk("conf.wbs0", 32'(wb_stall), 0);
    tick();
    commit_we = 1'b0;
    chk("conf.skid", 32'(skid_valid), 1);
    chk("conf.wbs1", 32'(wb_stall), 1);
    chk("conf.skidrd", 32'(skid_rd), 9);
    chk_rf("conf.drain", 1'b1, 5'd9, 32'h99);
    tick();
    chk("conf.empty", 32'(skid_valid), 0);
    chk_rf("conf.idle", 1'b0, 0, 0);

    // back-to-back retirements r3,r4,r5 with conflict on the first
    issue_valid = 1'b1; issue_rd = 5'd3; tick();
    issue_rd = 5'd4; tick();
    issue_rd = 5'd5; tick();
    issue_valid = 1'b0;
    repeat (2) tick();
    mul_data = 32'h300; commit_we = 1'b1; commit_rd = 5'd9; commit_data = 32'h909;
    #1;
    chk_rf("b2b.r3", 1'b1, 5'd3, 32'h300);
    tick();
    commit_we = 1'b0; mul_data = 32'h400; #1;
    chk("b2b.skid1", 32'(skid_valid), 1);
    chk_rf("b2b.r4", 1'b1, 5'd4, 32'h400);
    tick();
    mul_data = 32'h500; #1;
    chk("b2b.skid2", 32'(skid_valid), 1);
    chk_rf("b2b.r5", 1'b1, 5'd5, 32'h500);
    tick();
    chk("b2b.skid3", 32'(skid_valid), 1);
    chk_rf("b2b.r9", 1'b1, 5'd9, 32'h909);
    tick();
    chk("b2b.empty", 32'(skid_valid), 0);
    chk_rf("b2b.idle", 1'b0, 0, 0);

    // stall: MUL r12 frozen in stage 2 while the skid entry still drains
    issue_valid = 1'b1; issue_rd = 5'd1; tick();
    issue_valid = 1'b0; repeat (2) tick();
    issue_valid = 1'b1; issue_rd = 5'd12; tick();
    issue_valid = 1'b0; tick();
    mul_data = 32'h11; commit_we = 1'b1; commit_rd = 5'd9; commit_data = 32'h77;
    #1;
    chk_rf("stall.r1", 1'b1, 5'd1, 32'h11);
    tick();
    commit_we = 1'b0; stall = 1'b1; #1;
    chk_rf("stall.drain", 1'b1, 5'd9, 32'h77);
    chk("stall.v", 32'(mul_wb_valid), 32'h04);
    chk("stall.infl", 32'(mul_inflight), 1);
    tick();
    issue_valid = 1'b1; issue_rd = 5'd20;
    commit_we = 1'b1; commit_rd = 5'd15; commit_data = 32'h15;
    #1;
    chk_rf("stall.noc", 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall.hold", 32'(mul_wb_valid), 32'h04);
      chk("stall.hinfl", 32'(mul_inflight), 1);
      chk("stall.skid", 32'(skid_valid), 0);
    end
    commit_we = 1'b0;
    issue_valid = 1'b0; stall = 1'b0;
    tick();
    chk("stall.s3", 32'(mul_wb_valid), 32'h08);
    mul_data = 32'hC0C0;
    tick();
    chk("stall.s4", 32'(mul_wb_valid), 32'h10);
    chk_rf("stall.r12", 1'b1, 5'd12, 32'hC0C0);
    tick();
    chk("stall.done", 32'(mul_wb_valid), 0);

    // occupancy
    for (int i = 1; i <= 7; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      tick();
      chk("occ.up", 32'(mul_inflight), 32'((i > 5) ? 5 : i));
    end
    issue_valid = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      tick();
      chk("occ.down", 32'(mul_inflight), 32'(i));
    end

    // reset with three MULs in flight and a commit request
    issue_valid = 1'b1; issue_rd = 5'd21; tick();
    issue_rd = 5'd22; tick();
    issue_rd = 5'd23; tick();
    issue_valid = 1'b0;
    commit_we = 1'b1; commit_rd = 5'd2; commit_data = 32'h2;
    reset_n = 1'b0;
    #1;
    chk("mrst.valid", 32'(mul_wb_valid), 0);
    chk("mrst.rd", 32'(mul_wb_rd), 0);
    chk("mrst.infl", 32'(mul_inflight), 0);
    chk("mrst.skid", 32'(skid_valid), 0);
    chk_rf("mrst.rf", 1'b0, 0, 0);
    commit_we = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst.after", 32'(rf_we), 0);
      chk("mrst.av", 32'(mul_wb_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
